// File: rtl/clk_gate_ctrl.sv
// Gate-enable controller: turns bursty activity requests into a registered clock-gate enable
// with a wake settle window and an idle hold-off. Optional statistic: define GATE_STATS_EN.
module clk_gate_ctrl #(
   parameter int unsigned WAKE_CYCLES = 2,
   parameter int unsigned IDLE_CYCLES = 8,
   parameter int unsigned TMR_W       = 4,
   parameter int unsigned STAT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              force_on,
   output logic              gate_en,
   output logic              ready,
   output logic [1:0]        state
`ifdef GATE_STATS_EN
   ,
   output logic [STAT_W-1:0] gated_cycles
`endif
);

   localparam logic [1:0] StOff  = 2'b00;
   localparam logic [1:0] StWake = 2'b01;
   localparam logic [1:0] StOn   = 2'b10;
   localparam logic [1:0] StHold = 2'b11;

   localparam logic [TMR_W-1:0] WakeLoad = TMR_W'(WAKE_CYCLES - 1);
   localparam logic [TMR_W-1:0] IdleLoad = TMR_W'(IDLE_CYCLES - 1);

   logic [1:0]       state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             gate_en_q, gate_en_d;
   logic             ready_q, ready_d;
   logic             wake;

   assign wake = req | force_on;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      unique case (state_q)
         StOff: begin
            if (wake) begin
               state_d = StWake;
               timer_d = WakeLoad;
            end
         end
         StWake: begin
            // WAKE length is fixed; wake is deliberately not consulted here.
            if (timer_q == '0) begin
               state_d = StOn;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         StOn: begin
            if (!wake) begin
               state_d = StHold;
               timer_d = IdleLoad;
            end
         end
         StHold: begin
            if (wake) begin
               state_d = StOn;
               timer_d = '0;
            end else if (timer_q == '0) begin
               state_d = StOff;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: begin
            state_d = StOff;
            timer_d = '0;
         end
      endcase
      // Outputs are registered alongside state, so decode them from the next state.
      gate_en_d = (state_d != StOff);
      ready_d   = (state_d == StOn) || (state_d == StHold);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StOff;
         timer_q   <= '0;
         gate_en_q <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         gate_en_q <= gate_en_d;
         ready_q   <= ready_d;
      end
   end

   assign gate_en = gate_en_q;
   assign ready   = ready_q;
   assign state   = state_q;

`ifdef GATE_STATS_EN
   logic [STAT_W-1:0] gated_q, gated_d;

   always_comb begin
      gated_d = gated_q;
      if ((state_q == StOff) && (gated_q != '1)) begin
         gated_d = gated_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gated_q <= '0;
      end else begin
         gated_q <= gated_d;
      end
   end

   assign gated_cycles = gated_q;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed self-checking bench for clk_gate_ctrl (default parameters).
// Covers the gated-cycle statistic when GATE_STATS_EN is defined.
module tb_clk_gate_ctrl;

   logic        clk;
   logic        reset;
   logic        req;
   logic        force_on;
   logic        gate_en;
   logic        ready;
   logic [1:0]  state;
`ifdef GATE_STATS_EN
   logic [15:0] gated_cycles;
`endif

   int errors = 0;
   int checks = 0;

   clk_gate_ctrl #(
      .WAKE_CYCLES(2),
      .IDLE_CYCLES(8),
      .TMR_W      (4),
      .STAT_W     (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .force_on    (force_on),
      .gate_en     (gate_en),
      .ready       (ready),
      .state       (state)
`ifdef GATE_STATS_EN
      ,
      .gated_cycles(gated_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 ns past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset    = 1'b0;
      req      = 1'b0;
      force_on = 1'b0;
      repeat (3) step();
      checks++;
      if (gate_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_gate_en: got %b expected 0", gate_en);
      end
      checks++;
      if (ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: got %b expected 0", ready);
      end
      checks++;
      if (state !== 2'b00) begin
         errors++;
         $display("FAIL reset_state: got %b expected 00", state);
      end
      reset = 1'b1;
      step();
      checks++;
      if (state !== 2'b00 || gate_en !== 1'b0) begin
         errors++;
         $display("FAIL idle_stays_off: got state=%b gate_en=%b expected 00/0", state, gate_en);
      end
   endtask

   task automatic test_wake();
      req = 1'b1;
      step();  // edge E
      checks++;
      if (state !== 2'b01 || gate_en !== 1'b1 || ready !== 1'b0) begin
         errors++;
         $display("FAIL wake_e0: got state=%b gate_en=%b ready=%b expected 01/1/0",
                  state, gate_en, ready);
      end
      step();  // E+1
      checks++;
      if (state !== 2'b01 || ready !== 1'b0) begin
         errors++;
         $display("FAIL wake_e1: got state=%b ready=%b expected 01/0", state, ready);
      end
      step();  // E+2
      checks++;
      if (state !== 2'b10 || gate_en !== 1'b1 || ready !== 1'b1) begin
         errors++;
         $display("FAIL wake_e2: got state=%b gate_en=%b ready=%b expected 10/1/1",
                  state, gate_en, ready);
      end
   endtask

   task automatic test_idle();
      req = 1'b0;
      step();  // edge D
      checks++;
      if (state !== 2'b11 || gate_en !== 1'b1 || ready !== 1'b1) begin
         errors++;
         $display("FAIL idle_d0: got state=%b gate_en=%b ready=%b expected 11/1/1",
                  state, gate_en, ready);
      end
      for (int i = 1; i < 8; i++) begin
         step();
         checks++;
         if (state !== 2'b11 || gate_en !== 1'b1) begin
            errors++;
            $display("FAIL idle_hold_d%0d: got state=%b gate_en=%b expected 11/1",
                     i, state, gate_en);
         end
      end
      step();  // D+8
      checks++;
      if (state !== 2'b00 || gate_en !== 1'b0 || ready !== 1'b0) begin
         errors++;
         $display("FAIL idle_d8: got state=%b gate_en=%b ready=%b expected 00/0/0",
                  state, gate_en, ready);
      end
   endtask

   task automatic test_wake_ignores_req();
      req = 1'b1;
      step();  // E
      req = 1'b0;
      step();  // E+1: still in WAKE despite wake=0
      checks++;
      if (state !== 2'b01 || gate_en !== 1'b1) begin
         errors++;
         $display("FAIL wake_ignore_e1: got state=%b gate_en=%b expected 01/1", state, gate_en);
      end
      step();  // E+2
      checks++;
      if (state !== 2'b10 || ready !== 1'b1) begin
         errors++;
         $display("FAIL wake_ignore_e2: got state=%b ready=%b expected 10/1", state, ready);
      end
      step();  // ON samples wake=0
      checks++;
      if (state !== 2'b11) begin
         errors++;
         $display("FAIL wake_ignore_hold: got state=%b expected 11", state);
      end
   endtask

   // Enters from HOLD (timer=7); rewakes with a 4-cycle gap.
   task automatic test_gap_filter();
      req = 1'b1;
      step();
      checks++;
      if (state !== 2'b10) begin
         errors++;
         $display("FAIL gap_back_on: got state=%b expected 10", state);
      end
      req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (state !== 2'b11 || gate_en !== 1'b1) begin
            errors++;
            $display("FAIL gap_hold_%0d: got state=%b gate_en=%b expected 11/1", i, state, gate_en);
         end
      end
      req = 1'b1;
      step();
      checks++;
      if (state !== 2'b10 || gate_en !== 1'b1 || ready !== 1'b1) begin
         errors++;
         $display("FAIL gap_resume: got state=%b gate_en=%b ready=%b expected 10/1/1",
                  state, gate_en, ready);
      end
   endtask

   // wake arriving on the same edge as timer expiry must win.
   task automatic test_expiry_priority();
      req = 1'b0;
      repeat (8) step();  // D .. D+7, timer reaches 0
      checks++;
      if (state !== 2'b11 || gate_en !== 1'b1) begin
         errors++;
         $display("FAIL prio_pre: got state=%b gate_en=%b expected 11/1", state, gate_en);
      end
      req = 1'b1;
      step();
      checks++;
      if (state !== 2'b10 || gate_en !== 1'b1) begin
         errors++;
         $display("FAIL prio_on: got state=%b gate_en=%b expected 10/1", state, gate_en);
      end
   endtask

   task automatic test_force_on();
      req      = 1'b0;
      force_on = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         checks++;
         if (state !== 2'b10 || gate_en !== 1'b1) begin
            errors++;
            $display("FAIL force_%0d: got state=%b gate_en=%b expected 10/1", i, state, gate_en);
         end
      end
      force_on = 1'b0;
   endtask

   task automatic test_reset_mid_hold();
      step();  // ON samples wake=0 -> HOLD
      checks++;
      if (state !== 2'b11) begin
         errors++;
         $display("FAIL rst_pre_hold: got state=%b expected 11", state);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (gate_en !== 1'b0 || ready !== 1'b0 || state !== 2'b00) begin
         errors++;
         $display("FAIL rst_async: got state=%b gate_en=%b ready=%b expected 00/0/0",
                  state, gate_en, ready);
      end
`ifdef GATE_STATS_EN
      checks++;
      if (gated_cycles !== 16'd0) begin
         errors++;
         $display("FAIL stats_clear: got %0d expected 0", gated_cycles);
      end
`endif
      @(negedge clk);
      reset = 1'b1;
      repeat (10) step();
      checks++;
      if (state !== 2'b00 || gate_en !== 1'b0) begin
         errors++;
         $display("FAIL rst_stay_off: got state=%b gate_en=%b expected 00/0", state, gate_en);
      end
`ifdef GATE_STATS_EN
      checks++;
      if (gated_cycles !== 16'd10) begin
         errors++;
         $display("FAIL stats_count: got %0d expected 10", gated_cycles);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_wake();
      test_idle();
      test_wake_ignores_req();
      test_gap_filter();
      test_expiry_priority();
      test_force_on();
      test_reset_mid_hold();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
